// File: rtl/spi_mult_master.sv
// SPI initiator for the multiplier peripheral: sends {opB,opA}, waits a gap, reads back the 8-bit product.
// Latency: (34 + 2*GAP_SCLKS) * CLK_DIV clk cycles from accepted start to the done pulse.
// Backpressure: start is honoured only in IDLE; requests while busy (including the done cycle) are dropped.
module spi_mult_master #(
    parameter int CLK_DIV   = 8,
    parameter int GAP_SCLKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] opA,
    input  logic [3:0] opB,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       MOSI,
    output logic       SCLK,
    output logic       CS,
    input  logic       MISO
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP_SCLKS) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, WRITE, GAP, READ, HOLD, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      res_q, res_d;
    logic            mosi_q, mosi_d;
    logic            sclk_q, sclk_d;
    logic            cs_q, cs_d;
    logic            tick;

    assign tick   = (state_q != IDLE) && (div_q == DW'(CLK_DIV - 1));
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign result = res_q;
    assign MOSI   = mosi_q;
    assign SCLK   = sclk_q;
    assign CS     = cs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            res_q   <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            res_q   <= res_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        res_d   = res_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = {opB, opA};
                    rx_d    = '0;
                    cs_d    = 1'b0;
                    mosi_d  = opB[3];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = WRITE;
            end
            WRITE: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // Falling edge: present the next bit, or park MOSI low after bit 0.
                    if (sclk_q) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            mosi_d  = 1'b0;
                            state_d = GAP;
                        end else begin
                            mosi_d = tx_q[6];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        if (gap_q == GW'(GAP_SCLKS - 1)) begin
                            gap_d   = '0;
                            state_d = READ;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
            end
            READ: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // Peripheral changes MISO after the rise, so it is stable by the fall.
                    if (sclk_q) begin
                        rx_d  = {rx_q[6:0], MISO};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    res_d   = rx_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_mult_master.sv
// Bench for spi_mult_master: random and directed transactions against a behavioural multiplier peripheral.
module tb_spi_mult_master;

    localparam int D  = 8;
    localparam int G  = 4;
    localparam int D2 = 2;
    localparam int G2 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic [3:0] opA = '0, opB = '0, opA2 = '0, opB2 = '0;
    logic       busy, done, MOSI, SCLK, CS;
    logic       busy2, done2, mosi2, sclk2, cs2;
    logic [7:0] result, result2;
    logic       MISO = 1'b0, miso2 = 1'b0;

    always #5 clk = ~clk;

    spi_mult_master #(.CLK_DIV(D), .GAP_SCLKS(G)) dut (
        .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .result(result),
        .MOSI(MOSI), .SCLK(SCLK), .CS(CS), .MISO(MISO));

    spi_mult_master #(.CLK_DIV(D2), .GAP_SCLKS(G2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .opA(opA2), .opB(opB2),
        .busy(busy2), .done(done2), .result(result2),
        .MOSI(mosi2), .SCLK(sclk2), .CS(cs2), .MISO(miso2));

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Peripheral model: captures the first 8 MOSI bits on rises, answers with their product in the read phase.
    int         rises = 0, rises2 = 0;
    logic [7:0] prx = '0, presp = '0, prx2 = '0, presp2 = '0;

    always @(negedge CS) begin rises = 0; prx = '0; end
    always @(posedge SCLK) if (!CS) begin
        rises++;
        if (rises <= 8) prx = {prx[6:0], MOSI};
        if (rises == 8) presp = 8'(prx[3:0]) * 8'(prx[7:4]);
        if (rises > 8 + G && rises <= 16 + G) MISO = presp[16 + G - rises];
    end

    always @(negedge cs2) begin rises2 = 0; prx2 = '0; end
    always @(posedge sclk2) if (!cs2) begin
        rises2++;
        if (rises2 <= 8) prx2 = {prx2[6:0], mosi2};
        if (rises2 == 8) presp2 = 8'(prx2[3:0]) * 8'(prx2[7:4]);
        if (rises2 > 8 + G2 && rises2 <= 16 + G2) miso2 = presp2[16 + G2 - rises2];
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] res;
        int         t0;
    } exp_t;
    exp_t sb[$];

    // Monitor: every done pulse is matched against the oldest accepted request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", cyc - e.t0, (34 + 2 * G) * D);
                check("mosi_byte", prx, e.tx);
                check("sclk_rises", rises, 16 + G);
                check("cs_at_done", CS, 1);
            end
        end
    end

    task automatic do_start(input logic [3:0] a, input logic [3:0] b, input bit accept);
        exp_t e;
        @(negedge clk);
        opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (accept) begin
            e.tx  = {b, a};
            e.res = 8'(a) * 8'(b);
            e.t0  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        if (i == 2000) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_rises(input int n);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rises >= n) break;
        end
        if (i == 2000) check("wait_rises_timeout", 1, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs"}, CS, 1);
        check({tag, "_sclk"}, SCLK, 0);
        check({tag, "_mosi"}, MOSI, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
    endtask

    initial begin
        int t0, last_t, bad_cs, bad_half, k;
        logic last_s;
        bit   seen;

        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;

        // 3 x 5
        do_start(4'd3, 4'd5, 1);
        wait_idle();

        // 15 x 15, with a start on the done cycle that must be ignored
        do_start(4'd15, 4'd15, 1);
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen_ff", done, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_on_done_ignored", busy, 0);

        // re-pulse during WRITE must not disturb the running transfer
        do_start(4'd3, 4'd5, 1);
        wait_rises(4);
        check("busy_in_write", busy, 1);
        do_start(4'd1, 4'd1, 0);
        wait_idle();
        repeat (50) @(negedge clk);
        check("no_second_txn", busy, 0);

        for (int n = 0; n < 5; n++) begin
            do_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
            wait_idle();
        end

        // reset in the read phase aborts without a done pulse
        do_start(4'd3, 4'd5, 1);
        wait_rises(8 + G + 4);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        sb.delete();
        repeat (5) @(negedge clk);
        check("midrst_done_low", done, 0);
        reset = 1'b0;
        do_start(4'd2, 4'd7, 1);
        wait_idle();

        // fast divider instance: every half-period 2 cycles, CS held low until done
        @(negedge clk);
        opA2 = 4'd6; opB2 = 4'd9; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        t0 = cyc;
        last_t = -1;
        last_s = sclk2;
        bad_cs = 0;
        bad_half = 0;
        seen = 0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done2) begin seen = 1; break; end
            if (cs2 !== 1'b0) bad_cs++;
            if (sclk2 !== last_s) begin
                if (last_t >= 0 && cyc - last_t != 2) bad_half++;
                last_t = cyc;
                last_s = sclk2;
            end
        end
        check("d2_done_seen", seen, 1);
        check("d2_latency", cyc - t0, 72);
        check("d2_result", result2, 8'h36);
        check("d2_mosi_byte", prx2, 8'h96);
        check("d2_cs_low", bad_cs, 0);
        check("d2_sclk_half", bad_half, 0);
        check("d2_rises", rises2, 17);
        @(negedge clk);
        check("d2_idle_after", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/spi_mult_master.md
Name: spi_mult_master

Overview:
SPI initiator that drives the multiplier peripheral from the system side. It accepts two 4-bit operands on a start strobe and shifts the operand byte out on MOSI. It then idles SCLK through a gap while the peripheral multiplies, shifts the 8-bit product back in on MISO, and presents it with a done pulse. It sits in the host-side test/system top, wired directly to the peripheral's MOSI/SCLK/CS/MISO pins.

Parameters:
CLK_DIV, 8, clk cycles per SCLK half-period (>=2)
GAP_SCLKS, 4, full SCLK periods between write and read phases (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle request; sampled only in IDLE
opA  input  4  multiplicand, sent as operand byte [3:0]
opB  input  4  multiplier, sent as operand byte [7:4]
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse when result valid
result  output  8  product; holds until next accepted start
MOSI  output  1  serial data to peripheral
SCLK  output  1  serial clock, idle low (CPOL=0)
CS  output  1  chip select, active low, idle high
MISO  input  1  serial data from peripheral

Behaviour:
- Reset (async, any state): state=IDLE, CS=1, SCLK=0, MOSI=0, busy=0, done=0, result=0x00, counters=0, shift regs=0.
- Reset mid-transfer aborts immediately: CS rises and SCLK drops in the same instant; no done pulse.
- Half-period tick: divider counts 0..CLK_DIV-1 while not IDLE; tick on terminal count, then wraps to 0. Every SCLK toggle and phase step occurs on a tick.
- start in IDLE: latch {opB,opA} into the TX shift reg, clear the RX shift reg, drive CS=0, load MOSI=opB[3] (bit 7), set busy, go to SETUP. start while busy is ignored; operands are not re-latched.
- SETUP: 1 half-period with SCLK low, then go to WRITE.
- WRITE: 8 SCLK periods, MSB first. SCLK rises on tick (peripheral samples MOSI). On the next tick SCLK falls and MOSI advances to the next bit. After the 8th falling edge, MOSI=0 and go to GAP.
- GAP: GAP_SCLKS full SCLK periods toggled as normal, MOSI=0, MISO ignored. Then go to READ.
- READ: 8 SCLK periods. Peripheral updates MISO after SCLK rise. Master samples MISO on each SCLK falling edge, shifting left into the RX reg (first sampled bit = result[7]). After the 8th fall, go to HOLD.
- HOLD: 1 half-period with SCLK low, CS still 0. On its tick: CS=1, result=RX reg, done=1 for one cycle, busy=1 for that cycle. Next cycle: IDLE, busy=0, done=0.
- Transaction length from start acceptance to done: (2 + 16 + 2*GAP_SCLKS + 16) * CLK_DIV clk cycles; 336 at defaults.
- Bit counter: 3 bits, wraps 7->0 at each phase end. GAP uses a separate counter of width clog2(GAP_SCLKS)+1.
- SCLK never glitches. It is a registered output, only toggled on tick, low in IDLE/SETUP/HOLD.
- start asserted on the same cycle as done: ignored, because the state is not yet IDLE.

Test Plan:
- Reset values: assert reset mid-sim -> CS=1, SCLK=0, MOSI=0, busy=0, done=0, result=0x00 asynchronously, before the next clk edge.
- opA=3, opB=5, MISO driven from a bench model returning 0x0F -> MOSI bits sampled at SCLK rises = 0x53 MSB first; result=0x0F; done pulses exactly 336 cycles after start.
- opA=15, opB=15, model returns 0xE1 -> MOSI=0xFF, result=0xE1; 16 SCLK rises during WRITE+READ plus 4 in GAP, total 20.
- start re-pulsed with opA=1, opB=1 during WRITE of 3x5 -> MOSI still 0x53, single done, result=0x0F, no second transaction.
- reset asserted during READ bit 4 -> CS=1 immediately, no done. A following start with opA=2, opB=7 completes normally: MOSI=0x72, result=0x0E.
- CLK_DIV=2, GAP_SCLKS=1 -> each SCLK half-period is exactly 2 clk cycles; done at 72 cycles; CS low continuously from start+1 through done.
